// File: rtl/mma_tile_sequencer.sv
// Tile sequencer for an M x N x K matmul on a ROWS x COLS systolic array: n-tile -> m-chunk -> k-tile.
// Optional perf counters are built only when MMA_SEQ_PERF_CNT_EN is defined.
module mma_tile_sequencer #(
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int REG_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [REG_WIDTH-1:0]         m,
  input  logic [REG_WIDTH-1:0]         n,
  input  logic [REG_WIDTH-1:0]         k,
  input  logic                         bias_en,
  output logic                         busy,
  output logic                         done,
  output logic                         cfg_err,
  output logic                         bias_req,
  input  logic                         bias_done,
  output logic                         w_req,
  input  logic                         w_done,
  output logic                         ia_req,
  input  logic                         ia_done,
  output logic                         drain_req,
  input  logic                         drain_done,
  output logic [REG_WIDTH-1:0]         k_base,
  output logic [REG_WIDTH-1:0]         n_base,
  output logic [REG_WIDTH-1:0]         m_base,
  output logic [$clog2(ROWS+1)-1:0]    w_valid_rows,
  output logic [$clog2(COLS+1)-1:0]    w_valid_cols,
  output logic [$clog2(ROWS+1)-1:0]    ia_valid_rows,
  output logic                         acc_init,
  output logic                         last_k,
  output logic                         last_tile,
  output logic [31:0]                  perf_w_loads,
  output logic [31:0]                  perf_stall_cycles
);

  localparam int RVW = $clog2(ROWS+1);
  localparam int CVW = $clog2(COLS+1);
  localparam logic [REG_WIDTH:0]   ROW_STEP = (REG_WIDTH+1)'(ROWS);
  localparam logic [REG_WIDTH:0]   COL_STEP = (REG_WIDTH+1)'(COLS);
  localparam logic [REG_WIDTH-1:0] ROW_INC  = REG_WIDTH'(ROWS);
  localparam logic [REG_WIDTH-1:0] COL_INC  = REG_WIDTH'(COLS);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_BIAS, S_WLOAD, S_IALOAD, S_DRAIN, S_DONE
  } state_e;

  // One extra bit so base+step cannot wrap near the top of the register range.
  function automatic logic exhausted(input logic [REG_WIDTH-1:0] base,
                                     input logic [REG_WIDTH:0]   step,
                                     input logic [REG_WIDTH-1:0] dim);
    return ({1'b0, base} + step) >= {1'b0, dim};
  endfunction

  function automatic logic [REG_WIDTH-1:0] clip(input logic [REG_WIDTH-1:0] dim,
                                                input logic [REG_WIDTH-1:0] base,
                                                input logic [REG_WIDTH-1:0] lim);
    logic [REG_WIDTH-1:0] rem;
    rem = dim - base;
    return (rem < lim) ? rem : lim;
  endfunction

  state_e               state_q, state_d;
  logic [REG_WIDTH-1:0] m_q, m_d, n_q, n_d, k_q, k_d;
  logic [REG_WIDTH-1:0] k_base_q, k_base_d, n_base_q, n_base_d, m_base_q, m_base_d;
  logic [REG_WIDTH-1:0] res_k_q, res_k_d, res_n_q, res_n_d;
  logic                 res_valid_q, res_valid_d, bias_en_q, bias_en_d, cfg_err_q, cfg_err_d;
  logic                 busy_q, done_q, bias_req_q, w_req_q, ia_req_q, drain_req_q;
  logic [RVW-1:0]       w_valid_rows_q, ia_valid_rows_q;
  logic [CVW-1:0]       w_valid_cols_q;
  logic                 acc_init_q, last_k_q, last_tile_q;

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    m_d         = m_q;
    n_d         = n_q;
    k_d         = k_q;
    bias_en_d   = bias_en_q;
    k_base_d    = k_base_q;
    n_base_d    = n_base_q;
    m_base_d    = m_base_q;
    res_valid_d = res_valid_q;
    res_k_d     = res_k_q;
    res_n_d     = res_n_q;
    cfg_err_d   = cfg_err_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        m_d         = m;
        n_d         = n;
        k_d         = k;
        bias_en_d   = bias_en;
        k_base_d    = '0;
        n_base_d    = '0;
        m_base_d    = '0;
        res_valid_d = 1'b0;
        cfg_err_d   = 1'b0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (m_q == '0 || n_q == '0 || k_q == '0) begin
          cfg_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          state_d = bias_en_q ? S_BIAS : S_WLOAD;
        end
      end
      S_BIAS: if (bias_done) state_d = S_WLOAD;
      S_WLOAD: if (w_done) begin
        res_valid_d = 1'b1;
        res_k_d     = k_base_q;
        res_n_d     = n_base_q;
        state_d     = S_IALOAD;
      end
      S_IALOAD: if (ia_done) begin
        if (!exhausted(k_base_q, ROW_STEP, k_q)) begin
          k_base_d = k_base_q + ROW_INC;
          state_d  = S_WLOAD;
        end else begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (drain_done) begin
        k_base_d = '0;
        if (!exhausted(m_base_q, ROW_STEP, m_q)) begin
          m_base_d = m_base_q + ROW_INC;
          state_d  = S_WLOAD;
        end else if (!exhausted(n_base_q, COL_STEP, n_q)) begin
          m_base_d = '0;
          n_base_d = n_base_q + COL_INC;
          state_d  = bias_en_q ? S_BIAS : S_WLOAD;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Resident weight tile already matches: fold the skipped load into this edge.
    if (state_d == S_WLOAD && state_q != S_WLOAD && res_valid_d &&
        res_k_d == k_base_d && res_n_d == n_base_d)
      state_d = S_IALOAD;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      {m_q, n_q, k_q} <= '0;
      {k_base_q, n_base_q, m_base_q, res_k_q, res_n_q} <= '0;
      {res_valid_q, bias_en_q, cfg_err_q} <= '0;
      {busy_q, done_q, bias_req_q, w_req_q, ia_req_q, drain_req_q} <= '0;
      {w_valid_rows_q, w_valid_cols_q, ia_valid_rows_q} <= '0;
      {acc_init_q, last_k_q, last_tile_q} <= '0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      n_q         <= n_d;
      k_q         <= k_d;
      bias_en_q   <= bias_en_d;
      k_base_q    <= k_base_d;
      n_base_q    <= n_base_d;
      m_base_q    <= m_base_d;
      res_valid_q <= res_valid_d;
      res_k_q     <= res_k_d;
      res_n_q     <= res_n_d;
      cfg_err_q   <= cfg_err_d;
      busy_q      <= (state_d != S_IDLE);
      done_q      <= (state_d == S_DONE);
      bias_req_q  <= (state_d == S_BIAS);
      w_req_q     <= (state_d == S_WLOAD);
      ia_req_q    <= (state_d == S_IALOAD);
      drain_req_q <= (state_d == S_DRAIN);
      // Tile descriptors follow the next bases so they are valid the cycle a req rises.
      if (state_d != S_IDLE) begin
        w_valid_rows_q  <= RVW'(clip(k_d, k_base_d, ROW_INC));
        w_valid_cols_q  <= CVW'(clip(n_d, n_base_d, COL_INC));
        ia_valid_rows_q <= RVW'(clip(m_d, m_base_d, ROW_INC));
        acc_init_q      <= (k_base_d == '0);
        last_k_q        <= exhausted(k_base_d, ROW_STEP, k_d);
        last_tile_q     <= exhausted(k_base_d, ROW_STEP, k_d) &&
                           exhausted(m_base_d, ROW_STEP, m_d) &&
                           exhausted(n_base_d, COL_STEP, n_d);
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign cfg_err       = cfg_err_q;
  assign bias_req      = bias_req_q;
  assign w_req         = w_req_q;
  assign ia_req        = ia_req_q;
  assign drain_req     = drain_req_q;
  assign k_base        = k_base_q;
  assign n_base        = n_base_q;
  assign m_base        = m_base_q;
  assign w_valid_rows  = w_valid_rows_q;
  assign w_valid_cols  = w_valid_cols_q;
  assign ia_valid_rows = ia_valid_rows_q;
  assign acc_init      = acc_init_q;
  assign last_k        = last_k_q;
  assign last_tile     = last_tile_q;

`ifdef MMA_SEQ_PERF_CNT_EN
  logic [31:0] perf_w_loads_q, perf_stall_q;
  logic        stall_now;

  assign stall_now = (bias_req_q & ~bias_done) | (w_req_q & ~w_done) |
                     (ia_req_q & ~ia_done) | (drain_req_q & ~drain_done);

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_IDLE && start)) begin
      perf_w_loads_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (state_q == S_WLOAD && w_done && perf_w_loads_q != '1)
        perf_w_loads_q <= perf_w_loads_q + 32'd1;
      if (stall_now && perf_stall_q != '1)
        perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_w_loads      = perf_w_loads_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_w_loads      = '0;
  assign perf_stall_cycles = '0;
`endif

endmodule

// File: doc/mma_tile_sequencer.md
# mma_tile_sequencer

- Parametrised successor to the MMA controller.
- Walks an M×N×K matrix multiply over a non-square ROWS×COLS systolic array, one tile at a time.
- Drives loaders through req/done handshakes: bias, weight, input activation (IA), and drain (requant + store).
- Computes per-tile valid extents, accumulator-init flags and last-tile flags.
- Skips a weight reload when the resident weight tile is unchanged.

## Interface

Parameters:
- ROWS, 16: array rows; K-extent of a weight tile; IA rows per chunk.
- COLS, 16: array columns; N-extent of a weight tile.
- REG_WIDTH, 32: dimension register width.

Ports:
- clk  in  1  clock. One clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  pulse; sampled only in IDLE.
- m, n, k  in  REG_WIDTH each  dimensions, latched on accepted start.
- bias_en  in  1  latched on start; enables the BIAS phase.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at end of job.
- cfg_err  out  1  high with done when any dimension is 0; cleared on next accepted start.
- bias_req / bias_done  out / in  1  bias load handshake.
- w_req / w_done  out / in  1  weight load handshake.
- ia_req / ia_done  out / in  1  IA load handshake.
- drain_req / drain_done  out / in  1  drain handshake (requant + store).
- k_base, n_base, m_base  out  REG_WIDTH each  tile origin.
- w_valid_rows  out  $clog2(ROWS+1)  = min(ROWS, k−k_base).
- w_valid_cols  out  $clog2(COLS+1)  = min(COLS, n−n_base).
- ia_valid_rows  out  $clog2(ROWS+1)  = min(ROWS, m−m_base).
- acc_init  out  1  high when k_base==0.
- last_k  out  1  high when k_base+ROWS ≥ k.
- last_tile  out  1  high when last_k, last m-chunk and last n-tile all hold.
- perf_w_loads  out  32  weight loads issued (see Configuration).
- perf_stall_cycles  out  32  cycles a req was high without its done (see Configuration).

## Operation

- Loop order: n-tile (outer) → m-chunk → k-tile (inner). Steps: n_base by COLS, m_base by ROWS, k_base by ROWS.
- States: IDLE, CHECK, BIAS, WLOAD, IALOAD, DRAIN, DONE.
- IDLE:
  - start=1 latches m, n, k, bias_en.
  - Clears bases to 0 and invalidates the weight-resident flag.
  - Goes to CHECK.
- CHECK:
  - Any dimension 0 → DONE with cfg_err=1.
  - Otherwise → BIAS if bias_en, else WLOAD.
- BIAS: entered once per n-tile, at m_base==0 and k_base==0. Goes to WLOAD.
- WLOAD:
  - Skipped (go straight to IALOAD) if the resident flag is set and the resident (k_base, n_base) equals the current one.
  - This happens only when k ≤ ROWS, i.e. a single k-tile.
  - On w_done: set the resident flag, record (k_base, n_base), go to IALOAD.
- IALOAD, on ia_done:
  - If not last_k: k_base += ROWS, go to WLOAD.
  - Otherwise go to DRAIN.
- DRAIN, on drain_done:
  - k_base = 0.
  - If m not exhausted: m_base += ROWS, go to WLOAD.
  - Else if n not exhausted: m_base = 0, n_base += COLS, go to BIAS (or WLOAD if bias_en=0).
  - Else go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Handshakes:
  - Each req rises on the cycle the state is entered and holds until its done is sampled high.
  - req drops on the next edge; the next state is entered on that same edge.
  - A done pulse arriving while its req is low is ignored.
- Stability: base, valid and flag outputs are registered and stable for the whole time any req is high.
- Arithmetic:
  - Remainders use REG_WIDTH unsigned subtraction, then min against ROWS/COLS.
  - "Exhausted" means base+step ≥ dim. Compare in REG_WIDTH+1 bits so it cannot wrap.
- start while busy: ignored.
- rst mid-operation: returns to IDLE next edge and drops all reqs. The job is abandoned.

## Timing

- Reset values: every output 0, state IDLE.
- start → busy high: 1 cycle. start → first req (bias_req or w_req) high: 2 cycles.
- done sampled at edge t → req low and next state's req high at edge t+1. Zero bubble between phases.
- Skipped WLOAD costs no cycle: the IALOAD decision is made on the same edge.
- Minimal job (single tile, bias_en=0, all dones answered same-cycle): start to done = 5 cycles.

## Configuration

- Macro MMA_SEQ_PERF_CNT_EN.
- Defined:
  - perf_w_loads increments on each w_done accepted in WLOAD.
  - perf_stall_cycles increments every cycle some req is high while its done is low.
  - Both counters clear on accepted start and on rst, and saturate at 2^32−1.
- Undefined: both ports stay in the interface and are driven to constant 0. No counter logic is synthesised.

## Test plan

- Single tile: m=n=k=16, ROWS=COLS=16, bias_en=1, dones same-cycle → bias, w, ia, drain once each; valid counts 16/16/16; acc_init=1; last_tile=1; done at cycle 6.
- Ragged tiling: k=40, n=20, m=5, bias_en=0 → 6 w_req; w_valid_rows sequence 16,16,8; w_valid_cols 16 then 4; ia_valid_rows=5; 2 drains; last_tile only on the final drain.
- Weight reuse: k=8, n=16, m=40 → exactly 1 w_req, 3 ia_req (ia_valid_rows 16,16,8), 3 drains; perf_w_loads=1 when the macro is defined.
- Config error: n=0 → no req ever; done and cfg_err high 2 cycles after start; the next start with valid dims clears cfg_err.
- Robustness:
  - Assert rst while w_req waits 10 cycles on w_done → all outputs 0 next cycle, state IDLE.
  - start pulses while busy are ignored.
  - A stray ia_done in WLOAD is ignored.
